// File: rtl/vx_writeback_arb_pkg.sv
// Shared widths and commit/writeback payload types for the writeback arbiter.
package vx_writeback_arb_pkg;

  localparam int unsigned NUM_UNITS   = 4;
  localparam int unsigned UNIT_IDX_W  = 2;
  localparam int unsigned NUM_THREADS = 4;
  localparam int unsigned XLEN        = 32;
  localparam int unsigned UUID_WIDTH  = 44;
  localparam int unsigned NW_BITS     = 2;
  localparam int unsigned NR_BITS     = 5;
  localparam int unsigned PC_BITS     = 32;
  localparam int unsigned COUNT_W     = 64;

  typedef enum logic [UNIT_IDX_W-1:0] {
    UNIT_ALU = 2'd0,
    UNIT_LSU = 2'd1,
    UNIT_FPU = 2'd2,
    UNIT_SFU = 2'd3
  } unit_e;

  typedef struct packed {
    logic [UUID_WIDTH-1:0]       uuid;
    logic [NW_BITS-1:0]          wid;
    logic [NUM_THREADS-1:0]      tmask;
    logic [PC_BITS-1:0]          pc;
    logic                        wb;
    logic [NR_BITS-1:0]          rd;
    logic [NUM_THREADS*XLEN-1:0] data;
    logic                        sop;
    logic                        eop;
  } commit_data_t;

  typedef struct packed {
    logic [UUID_WIDTH-1:0]       uuid;
    logic [NW_BITS-1:0]          wid;
    logic [NUM_THREADS-1:0]      tmask;
    logic [PC_BITS-1:0]          pc;
    logic [NR_BITS-1:0]          rd;
    logic [NUM_THREADS*XLEN-1:0] data;
    logic                        sop;
    logic                        eop;
  } wb_data_t;

  // Writeback payload is the commit payload minus the wb enable.
  function automatic wb_data_t to_wb(commit_data_t c);
    wb_data_t w;
    w.uuid  = c.uuid;
    w.wid   = c.wid;
    w.tmask = c.tmask;
    w.pc    = c.pc;
    w.rd    = c.rd;
    w.data  = c.data;
    w.sop   = c.sop;
    w.eop   = c.eop;
    return w;
  endfunction

endpackage

// File: rtl/vx_writeback_arb_rr_arbiter.sv
// Round-robin arbiter with optional packet lock; grant is combinational,
// priority moves past the winner only when it fires with unlock set.
module vx_writeback_arb_rr_arbiter #(
  parameter int unsigned NUM_REQS    = 4,
  parameter int unsigned IDX_W       = 2,
  parameter bit          LOCK_ENABLE = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] requests,
  input  logic                unlock,
  output logic [NUM_REQS-1:0] grant,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                grant_valid
);

  logic [IDX_W-1:0] prio_q, prio_d;
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

  logic [IDX_W:0]   cand;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             fire;

  // Scan from the priority pointer; a held lock overrides the scan.
  always_comb begin
    cand       = '0;
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      cand = {1'b0, prio_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQS)) begin
        cand = cand - (IDX_W+1)'(NUM_REQS);
      end
      if (!pick_found && requests[cand[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end

    grant_idx   = lock_q ? lock_idx_q : pick_idx;
    grant_valid = !reset && (lock_q || pick_found);
    grant       = '0;
    if (grant_valid) begin
      grant[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    prio_d     = prio_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    fire       = grant_valid && requests[grant_idx];
    if (fire) begin
      if (unlock || !LOCK_ENABLE) begin
        lock_d = 1'b0;
        prio_d = (grant_idx == IDX_W'(NUM_REQS - 1)) ? '0 : grant_idx + IDX_W'(1);
      end else begin
        lock_d     = 1'b1;
        lock_idx_d = grant_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q     <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      prio_q     <= prio_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: rtl/vx_writeback_arb.sv
// Per-issue-slot writeback arbiter: picks one commit unit per cycle, registers
// the writeback payload and counts retired instructions.
module vx_writeback_arb
  import vx_writeback_arb_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic         [NUM_UNITS-1:0] commit_valid,
  input  commit_data_t [NUM_UNITS-1:0] commit_data,
  output logic         [NUM_UNITS-1:0] commit_ready,
  output logic                         wb_valid,
  output wb_data_t                     wb_data,
  output logic         [COUNT_W-1:0]   commit_count
);

  logic [NUM_UNITS-1:0]  grant;
  logic [UNIT_IDX_W-1:0] grant_idx;
  logic                  grant_valid;
  commit_data_t          sel;
  logic                  fire;

  logic                  wb_valid_q, wb_valid_d;
  wb_data_t              wb_data_q, wb_data_d;
  logic [COUNT_W-1:0]    count_q, count_d;

  vx_writeback_arb_rr_arbiter #(
    .NUM_REQS    (NUM_UNITS),
    .IDX_W       (UNIT_IDX_W),
    .LOCK_ENABLE (1'b1)
  ) u_rr_arbiter (
    .clk         (clk),
    .reset       (reset),
    .requests    (commit_valid),
    .unlock      (sel.eop),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign sel  = commit_data[grant_idx];
  assign fire = grant_valid && commit_valid[grant_idx];

  // wb=0 commits retire silently; wb_data keeps its last value when idle.
  always_comb begin
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    count_d    = count_q;
    if (fire) begin
      wb_valid_d = sel.wb;
      if (sel.wb) begin
        wb_data_d = to_wb(sel);
      end
      if (sel.eop) begin
        count_d = count_q + COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      count_q    <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      count_q    <= count_d;
    end
  end

  assign commit_ready = grant;
  assign wb_valid     = wb_valid_q;
  assign wb_data      = wb_data_q;
  assign commit_count = count_q;

endmodule

// File: tb/tb_vx_writeback_arb.sv
// Randomized bench for vx_writeback_arb against a transaction-level model of
// round-robin grant, packet lock, writeback latency and retire count.
module tb_vx_writeback_arb;
  import vx_writeback_arb_pkg::*;

  logic                         clk;
  logic                         reset;
  logic         [NUM_UNITS-1:0] commit_valid;
  commit_data_t [NUM_UNITS-1:0] commit_data;
  logic         [NUM_UNITS-1:0] commit_ready;
  logic                         wb_valid;
  wb_data_t                     wb_data;
  logic         [COUNT_W-1:0]   commit_count;

  vx_writeback_arb dut (
    .clk          (clk),
    .reset        (reset),
    .commit_valid (commit_valid),
    .commit_data  (commit_data),
    .commit_ready (commit_ready),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data),
    .commit_count (commit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model
  int           prio;
  int           locked;
  logic         exp_wb_valid;
  wb_data_t     exp_wb_data;
  logic [63:0]  exp_count;

  // stimulus / source state
  logic                 rst_in;
  logic [NUM_UNITS-1:0] cv;
  commit_data_t         cd [NUM_UNITS];
  int                   fired_unit;
  bit                   hold [NUM_UNITS];
  int                   left [NUM_UNITS];

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic wb_data_t wb_of(input commit_data_t c);
    wb_data_t w;
    w.uuid  = c.uuid;
    w.wid   = c.wid;
    w.tmask = c.tmask;
    w.pc    = c.pc;
    w.rd    = c.rd;
    w.data  = c.data;
    w.sop   = c.sop;
    w.eop   = c.eop;
    return w;
  endfunction

  function automatic commit_data_t rand_beat();
    commit_data_t c;
    c.uuid  = UUID_WIDTH'({$urandom(), $urandom()});
    c.wid   = NW_BITS'($urandom());
    c.tmask = NUM_THREADS'($urandom());
    c.pc    = $urandom();
    c.wb    = ($urandom_range(3) != 0);
    c.rd    = NR_BITS'($urandom());
    c.data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    c.sop   = 1'b0;
    c.eop   = 1'b0;
    return c;
  endfunction

  task automatic model_reset();
    prio         = 0;
    locked       = -1;
    exp_wb_valid = 1'b0;
    exp_wb_data  = '0;
    exp_count    = '0;
  endtask

  // One clock: check registered outputs, apply inputs, check grant, advance model.
  task automatic step();
    int                   g;
    logic [NUM_UNITS-1:0] er;
    @(negedge clk);
    check_eq("wb_valid", 256'(wb_valid), 256'(exp_wb_valid));
    check_eq("wb_data", 256'(wb_data), 256'(exp_wb_data));
    check_eq("commit_count", 256'(commit_count), 256'(exp_count));
    reset        = rst_in;
    commit_valid = cv;
    for (int u = 0; u < NUM_UNITS; u++) commit_data[u] = cd[u];
    #1;
    g = -1;
    if (locked >= 0) begin
      g = locked;
    end else begin
      for (int k = 0; k < NUM_UNITS; k++) begin
        int u;
        u = (prio + k) % NUM_UNITS;
        if (g < 0 && cv[u]) g = u;
      end
    end
    er = '0;
    if (!rst_in && g >= 0) er[g] = 1'b1;
    check_eq("commit_ready", 256'(commit_ready), 256'(er));
    fired_unit = -1;
    if (rst_in) begin
      model_reset();
    end else begin
      exp_wb_valid = 1'b0;
      if (g >= 0 && cv[g]) begin
        fired_unit = g;
        if (cd[g].wb) begin
          exp_wb_valid = 1'b1;
          exp_wb_data  = wb_of(cd[g]);
        end
        if (cd[g].eop) begin
          exp_count = exp_count + 64'd1;
          locked    = -1;
          prio      = (g + 1) % NUM_UNITS;
        end else begin
          locked = g;
        end
      end
    end
  endtask

  // Sources hold a presented beat until it fires; a reset discards packets.
  task automatic post();
    if (rst_in) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        hold[u] = 1'b0;
        left[u] = 0;
      end
    end else if (fired_unit >= 0) begin
      hold[fired_unit] = 1'b0;
      left[fired_unit] = left[fired_unit] - 1;
    end
  endtask

  task automatic gen(input int p_valid, input int p_reset);
    bit first;
    rst_in = ($urandom_range(999) < p_reset);
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (!hold[u]) begin
        if ($urandom_range(99) < p_valid) begin
          if (left[u] == 0) begin
            left[u] = $urandom_range(3, 1);
            first   = 1'b1;
          end else begin
            first = 1'b0;
          end
          cd[u]     = rand_beat();
          cd[u].sop = first;
          cd[u].eop = (left[u] == 1);
          hold[u]   = 1'b1;
          cv[u]     = 1'b1;
        end else begin
          cv[u] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    commit_valid = '0;
    commit_data  = '0;
    rst_in       = 1'b1;
    cv           = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      cd[u]   = '0;
      hold[u] = 1'b0;
      left[u] = 0;
    end
    repeat (2) @(posedge clk);
    model_reset();
    step(); post();
    rst_in = 1'b0;

    // Single ALU writeback commit.
    cv = '0;
    cv[UNIT_ALU]       = 1'b1;
    cd[UNIT_ALU]       = rand_beat();
    cd[UNIT_ALU].wb    = 1'b1;
    cd[UNIT_ALU].rd    = 5'd5;
    cd[UNIT_ALU].data  = {4{32'hDEADBEEF}};
    cd[UNIT_ALU].sop   = 1'b1;
    cd[UNIT_ALU].eop   = 1'b1;
    step(); post();
    cv = '0;
    step(); post();
    check_eq("alu_wb_valid", 256'(wb_valid), 256'(1'b1));
    check_eq("alu_rd", 256'(wb_data.rd), 256'(5'd5));
    check_eq("alu_data", 256'(wb_data.data), 256'({4{32'hDEADBEEF}}));
    check_eq("alu_count", 256'(commit_count), 256'(64'd1));

    // SFU commit without writeback still retires.
    cv[UNIT_SFU]     = 1'b1;
    cd[UNIT_SFU]     = rand_beat();
    cd[UNIT_SFU].wb  = 1'b0;
    cd[UNIT_SFU].sop = 1'b1;
    cd[UNIT_SFU].eop = 1'b1;
    step(); post();
    cv = '0;
    step(); post();
    check_eq("sfu_no_wb", 256'(wb_valid), 256'(1'b0));
    check_eq("sfu_count", 256'(commit_count), 256'(64'd2));

    // Random phases: saturated, moderate and sparse traffic with occasional reset.
    for (int i = 0; i < 2000; i++) begin gen(95, 3); step(); post(); end
    for (int i = 0; i < 2000; i++) begin gen(50, 3); step(); post(); end
    for (int i = 0; i < 2000; i++) begin gen(20, 3); step(); post(); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
